// File: rtl/mul_issue_ctrl_pkg.sv
// Shared definitions for the multiply issue controller: default widths,
// the 2-bit FSM state encoding and the latency-timer sizing helper.
package mul_issue_ctrl_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int TAG_WIDTH   = 5;
    localparam int OPCNT_WIDTH = 16;
    localparam int MUL_LATENCY = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } mic_state_e;

    // Narrowest counter that can hold the value LATENCY.
    function automatic int timer_width(input int latency);
        int w;
        w = $clog2(latency + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mul_issue_ctrl_timer.sv
// Latency down-counter: loaded with LATENCY, decremented while waiting;
// o_last flags the cycle whose closing edge brings the count to zero.
module mul_issue_ctrl_timer
    import mul_issue_ctrl_pkg::*;
#(
    parameter int LATENCY = MUL_LATENCY
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_load,
    input  logic i_dec,
    output logic o_last
);

    localparam int TW = timer_width(LATENCY);
    localparam logic [TW-1:0] LOAD_VAL = TW'(LATENCY);

    logic [TW-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - TW'(1);
        end
    end

    assign o_last = (r_count == TW'(1));

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller in front of the fixed-latency multiplier: one op in
// flight, registered enable/operands, result held for writeback under backpressure.
//
//  state | meaning
//  IDLE  | no op in flight, ready for a request
//  ISSUE | mul_enable high for this single cycle with latched operands
//  WAIT  | latency timer running; product captured as it expires
//  DONE  | product + tag presented to writeback until handshake
module mul_issue_ctrl
    import mul_issue_ctrl_pkg::*;
#(
    parameter int WIDTH   = DATA_WIDTH,
    parameter int TAG_W   = TAG_WIDTH,
    parameter int LATENCY = MUL_LATENCY,
    parameter int CNT_W   = OPCNT_WIDTH
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [WIDTH-1:0] i_req_op1,
    input  logic [WIDTH-1:0] i_req_op2,
    input  logic [TAG_W-1:0] i_req_tag,
    input  logic             i_flush,
    output logic             o_mul_enable,
    output logic [WIDTH-1:0] o_mul_op1,
    output logic [WIDTH-1:0] o_mul_op2,
    input  logic [WIDTH-1:0] i_mul_result,
    output logic             o_wb_valid,
    input  logic             i_wb_ready,
    output logic [WIDTH-1:0] o_wb_data,
    output logic [TAG_W-1:0] o_wb_tag,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_op_count
);

    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("mul_issue_ctrl: LATENCY must be at least 1");
        end
    endgenerate

    mic_state_e       r_state;
    mic_state_e       w_next_state;
    logic             r_mul_enable;
    logic [WIDTH-1:0] r_mul_op1;
    logic [WIDTH-1:0] r_mul_op2;
    logic [TAG_W-1:0] r_tag_pend;
    logic [WIDTH-1:0] r_wb_data;
    logic [TAG_W-1:0] r_wb_tag;
    logic [CNT_W-1:0] r_op_count;

    logic w_req_ready;
    logic w_accept;
    logic w_wb_hs;
    logic w_tmr_load;
    logic w_tmr_dec;
    logic w_tmr_last;
    logic w_capture;

    // Flush beats everything: no accept and no handshake in a flush cycle.
    assign w_req_ready = !i_flush &&
                         ((r_state == ST_IDLE) || ((r_state == ST_DONE) && i_wb_ready));
    assign w_accept    = i_req_valid && w_req_ready;
    assign w_wb_hs     = (r_state == ST_DONE) && i_wb_ready && !i_flush;

    mul_issue_ctrl_timer #(
        .LATENCY (LATENCY)
    ) u_timer (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (i_flush),
        .i_load  (w_tmr_load),
        .i_dec   (w_tmr_dec),
        .o_last  (w_tmr_last)
    );

    always_comb begin
        w_next_state = r_state;
        w_tmr_load   = 1'b0;
        w_tmr_dec    = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_tmr_load   = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                w_tmr_dec = 1'b1;
                if (w_tmr_last) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_wb_ready) w_next_state = w_accept ? ST_ISSUE : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (i_flush) begin
            w_next_state = ST_IDLE;
            w_tmr_load   = 1'b0;
            w_tmr_dec    = 1'b0;
            w_capture    = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_mul_enable <= 1'b0;
            r_mul_op1    <= '0;
            r_mul_op2    <= '0;
            r_tag_pend   <= '0;
            r_wb_data    <= '0;
            r_wb_tag     <= '0;
            r_op_count   <= '0;
        end else begin
            r_state      <= w_next_state;
            // Enable is high exactly for the ISSUE cycle.
            r_mul_enable <= (w_next_state == ST_ISSUE);
            if (w_accept) begin
                r_mul_op1  <= i_req_op1;
                r_mul_op2  <= i_req_op2;
                r_tag_pend <= i_req_tag;
            end
            // Tag moves to the writeback register with the product so it stays
            // paired with wb_data even while a new request is being latched.
            if (w_capture) begin
                r_wb_data <= i_mul_result;
                r_wb_tag  <= r_tag_pend;
            end
            if (w_wb_hs) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end
    end

    assign o_req_ready  = w_req_ready;
    assign o_mul_enable = r_mul_enable;
    assign o_mul_op1    = r_mul_op1;
    assign o_mul_op2    = r_mul_op2;
    assign o_wb_valid   = (r_state == ST_DONE);
    assign o_wb_data    = r_wb_data;
    assign o_wb_tag     = r_wb_tag;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_op_count   = r_op_count;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl with a one-cycle behavioural multiplier; a
// transaction-level model (pending op + due edge) predicts every output.
module tb_mul_issue_ctrl;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam int LAT   = 1;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [WIDTH-1:0] req_op1 = '0;
    logic [WIDTH-1:0] req_op2 = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             flush = 1'b0;
    logic             mul_enable;
    logic [WIDTH-1:0] mul_op1;
    logic [WIDTH-1:0] mul_op2;
    logic [WIDTH-1:0] mul_res = '0;
    logic             wb_valid;
    logic             wb_ready = 1'b0;
    logic [WIDTH-1:0] wb_data;
    logic [TAG_W-1:0] wb_tag;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    always #5 clk = ~clk;

    mul_issue_ctrl #(
        .WIDTH   (WIDTH),
        .TAG_W   (TAG_W),
        .LATENCY (LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clock      (clk),
        .i_reset      (reset),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op1    (req_op1),
        .i_req_op2    (req_op2),
        .i_req_tag    (req_tag),
        .i_flush      (flush),
        .o_mul_enable (mul_enable),
        .o_mul_op1    (mul_op1),
        .o_mul_op2    (mul_op2),
        .i_mul_result (mul_res),
        .o_wb_valid   (wb_valid),
        .i_wb_ready   (wb_ready),
        .o_wb_data    (wb_data),
        .o_wb_tag     (wb_tag),
        .o_busy       (busy),
        .o_op_count   (op_count)
    );

    // One-cycle multiplier: samples enable/operands on the edge, result valid after it.
    always_ff @(posedge clk) begin
        if (mul_enable) mul_res <= mul_op1 * mul_op2;
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: one pending op, the edge index at which its result shows up.
    bit               m_pend = 1'b0;
    bit               m_en   = 1'b0;
    bit               m_acc  = 1'b0;
    longint           m_edge = 0;
    longint           m_due  = 0;
    logic [WIDTH-1:0] m_op1  = '0;
    logic [WIDTH-1:0] m_op2  = '0;
    logic [WIDTH-1:0] m_data = '0;
    logic [TAG_W-1:0] m_tag  = '0;
    logic [CNT_W-1:0] m_count = '0;
    bit               prev_valid = 1'b0;
    longint           rise_q[$];

    task automatic cyc(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [TAG_W-1:0] t, input bit wr, input bit fl, input bit rs);
        bit          exp_valid;
        bit          exp_ready;
        logic [63:0] full;
        req_valid = v;
        req_op1   = a;
        req_op2   = b;
        req_tag   = t;
        wb_ready  = wr;
        flush     = fl;
        reset     = rs;
        @(negedge clk);
        exp_valid = m_pend && (m_edge >= m_due);
        exp_ready = !fl && (!m_pend || (exp_valid && wr));
        chk("req_ready",  64'(req_ready),  64'(exp_ready));
        chk("wb_valid",   64'(wb_valid),   64'(exp_valid));
        chk("busy",       64'(busy),       64'(m_pend));
        chk("mul_enable", 64'(mul_enable), 64'(m_en));
        chk("mul_op1",    64'(mul_op1),    64'(m_op1));
        chk("mul_op2",    64'(mul_op2),    64'(m_op2));
        chk("op_count",   64'(op_count),   64'(m_count));
        if (exp_valid) begin
            chk("wb_data", 64'(wb_data), 64'(m_data));
            chk("wb_tag",  64'(wb_tag),  64'(m_tag));
        end
        if (wb_valid && !prev_valid) rise_q.push_back(m_edge);
        prev_valid = wb_valid;

        m_edge++;
        m_acc = 1'b0;
        if (rs) begin
            m_pend  = 1'b0;
            m_en    = 1'b0;
            m_op1   = '0;
            m_op2   = '0;
            m_data  = '0;
            m_tag   = '0;
            m_count = '0;
        end else if (fl) begin
            m_pend = 1'b0;
            m_en   = 1'b0;
        end else begin
            m_en = 1'b0;
            if (exp_valid && wr) begin
                m_count = m_count + 1'b1;
                m_pend  = 1'b0;
            end
            if (v && exp_ready) begin
                full   = {32'b0, a} * {32'b0, b};
                m_pend = 1'b1;
                m_en   = 1'b1;
                m_acc  = 1'b1;
                m_due  = m_edge + 1 + LAT;
                m_op1  = a;
                m_op2  = b;
                m_data = full[WIDTH-1:0];
                m_tag  = t;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit wr);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, wr, 1'b0, 1'b0);
    endtask

    // Decode-style request: held until the model says it was accepted.
    task automatic req_hold(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [TAG_W-1:0] t, input bit wr);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc(1'b1, a, b, t, wr, 1'b0, 1'b0);
            done = m_acc;
        end
        chk("req_accept_timeout", 64'(done), 64'(1));
    endtask

    function automatic logic [WIDTH-1:0] rnd_op();
        case ($urandom_range(0, 4))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0001_0000;
            2:       return 32'(($urandom_range(0, 15)));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",     64'(busy),       64'(0));
        chk("rst_wb_valid", 64'(wb_valid),   64'(0));
        chk("rst_mul_en",   64'(mul_enable), 64'(0));
        chk("rst_mul_op1",  64'(mul_op1),    64'(0));
        chk("rst_mul_op2",  64'(mul_op2),    64'(0));
        chk("rst_wb_data",  64'(wb_data),    64'(0));
        chk("rst_wb_tag",   64'(wb_tag),     64'(0));
        chk("rst_op_count", 64'(op_count),   64'(0));

        // Basic 7*6 tag 5
        req_hold(32'd7, 32'd6, 5'd5, 1'b1);
        chk("basic_en_on", 64'(mul_enable), 64'(1));
        idle(1, 1'b0);
        chk("basic_en_off", 64'(mul_enable), 64'(0));
        chk("basic_not_yet", 64'(wb_valid), 64'(0));
        idle(1, 1'b0);
        chk("basic_valid", 64'(wb_valid), 64'(1));
        chk("basic_data",  64'(wb_data),  64'(42));
        chk("basic_tag",   64'(wb_tag),   64'(5));
        idle(1, 1'b1);
        chk("basic_count", 64'(op_count), 64'(1));

        // Truncation
        req_hold(32'hFFFF_FFFF, 32'd2, 5'd7, 1'b0);
        idle(2, 1'b0);
        chk("wrap1_data", 64'(wb_data), 64'hFFFF_FFFE);
        idle(1, 1'b1);
        req_hold(32'h0001_0000, 32'h0001_0000, 5'd8, 1'b0);
        idle(2, 1'b0);
        chk("wrap2_data", 64'(wb_data), 64'(0));
        chk("wrap2_valid", 64'(wb_valid), 64'(1));
        idle(1, 1'b1);

        // Backpressure with a second request held high
        req_hold(32'd9, 32'd9, 5'd3, 1'b0);
        idle(2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'd2, 32'd3, 5'd4, 1'b0, 1'b0, 1'b0);
            chk("bp_ready", 64'(req_ready), 64'(0));
            chk("bp_valid", 64'(wb_valid),  64'(1));
            chk("bp_data",  64'(wb_data),   64'(81));
            chk("bp_tag",   64'(wb_tag),    64'(3));
        end
        req_hold(32'd2, 32'd3, 5'd4, 1'b1);
        chk("bp_count", 64'(op_count), 64'(4));
        idle(2, 1'b0);
        chk("bp2_data", 64'(wb_data), 64'(6));
        chk("bp2_tag",  64'(wb_tag),  64'(4));
        idle(1, 1'b1);

        // Back-to-back
        rise_q.delete();
        req_hold(32'd3, 32'd4, 5'd1, 1'b1);
        req_hold(32'd5, 32'd5, 5'd2, 1'b1);
        idle(6, 1'b1);
        chk("b2b_results", 64'(rise_q.size()), 64'(2));
        if (rise_q.size() == 2) chk("b2b_spacing", 64'(rise_q[1] - rise_q[0]), 64'(LAT + 2));
        chk("b2b_count", 64'(op_count), 64'(7));

        // Flush in WAIT, flush in DONE, flush beating a request
        req_hold(32'd11, 32'd3, 5'd9, 1'b1);
        idle(1, 1'b1);
        cyc(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
        chk("flw_busy",  64'(busy),     64'(0));
        chk("flw_valid", 64'(wb_valid), 64'(0));
        idle(3, 1'b1);
        chk("flw_count", 64'(op_count), 64'(7));
        req_hold(32'd4, 32'd4, 5'd10, 1'b0);
        idle(2, 1'b0);
        cyc(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
        chk("fld_valid", 64'(wb_valid), 64'(0));
        chk("fld_count", 64'(op_count), 64'(7));
        cyc(1'b1, 32'd5, 32'd5, 5'd1, 1'b1, 1'b1, 1'b0);
        chk("flr_busy", 64'(busy), 64'(0));

        // Reset in WAIT
        req_hold(32'd6, 32'd7, 5'd11, 1'b1);
        idle(1, 1'b1);
        cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
        chk("rmo_busy",     64'(busy),       64'(0));
        chk("rmo_wb_valid", 64'(wb_valid),   64'(0));
        chk("rmo_mul_en",   64'(mul_enable), 64'(0));
        chk("rmo_mul_op1",  64'(mul_op1),    64'(0));
        chk("rmo_mul_op2",  64'(mul_op2),    64'(0));
        chk("rmo_wb_data",  64'(wb_data),    64'(0));
        chk("rmo_wb_tag",   64'(wb_tag),     64'(0));
        chk("rmo_op_count", 64'(op_count),   64'(0));
        req_hold(32'd2, 32'd9, 5'd12, 1'b1);
        idle(2, 1'b0);
        chk("rmo_data", 64'(wb_data), 64'(18));
        idle(1, 1'b1);
        chk("rmo_count", 64'(op_count), 64'(1));

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 99) < 60), rnd_op(), rnd_op(), 5'($urandom_range(0, 31)),
                ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 4),
                ($urandom_range(0, 99) < 1));
        end
        idle(4, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
